// File: rtl/image_codec_pkg.sv
// Shared definitions for the image codec: block size, forward quantization
// factors, the matching dequantization steps and the 16-bit saturation helper.
package image_codec_pkg;

    localparam int unsigned BLOCK_N = 64;
    localparam int unsigned PROD_W  = 25;

    typedef logic signed [15:0] coef_t;

    // Forward factors; the quantizer and dequantizer must stay paired.
    localparam logic [7:0] QUANT_MUL [BLOCK_N] = '{
        8'd16, 8'd21, 8'd18, 8'd12, 8'd8,  8'd5,  8'd4,  8'd3,
        8'd20, 8'd19, 8'd14, 8'd9,  8'd6,  8'd4,  8'd3,  8'd3,
        8'd14, 8'd12, 8'd8,  8'd6,  8'd4,  8'd3,  8'd3,  8'd3,
        8'd10, 8'd8,  8'd6,  8'd4,  8'd3,  8'd3,  8'd3,  8'd2,
        8'd7,  8'd5,  8'd4,  8'd3,  8'd3,  8'd3,  8'd2,  8'd2,
        8'd5,  8'd4,  8'd3,  8'd3,  8'd3,  8'd2,  8'd2,  8'd2,
        8'd4,  8'd3,  8'd3,  8'd3,  8'd2,  8'd2,  8'd2,  8'd2,
        8'd3,  8'd3,  8'd3,  8'd2,  8'd2,  8'd2,  8'd2,  8'd2
    };

    // round(256 / QUANT_MUL[i])
    localparam logic [7:0] DEQ_STEP [BLOCK_N] = '{
        8'd16, 8'd12, 8'd14, 8'd21, 8'd32, 8'd51, 8'd64, 8'd85,
        8'd13, 8'd13, 8'd18, 8'd28, 8'd43, 8'd64, 8'd85, 8'd85,
        8'd18, 8'd21, 8'd32, 8'd43, 8'd64, 8'd85, 8'd85, 8'd85,
        8'd26, 8'd32, 8'd43, 8'd64, 8'd85, 8'd85, 8'd85, 8'd128,
        8'd37, 8'd51, 8'd64, 8'd85, 8'd85, 8'd85, 8'd128, 8'd128,
        8'd51, 8'd64, 8'd85, 8'd85, 8'd85, 8'd128, 8'd128, 8'd128,
        8'd64, 8'd85, 8'd85, 8'd85, 8'd128, 8'd128, 8'd128, 8'd128,
        8'd85, 8'd85, 8'd85, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128
    };

    function automatic coef_t sat16(input logic signed [PROD_W-1:0] p);
        if (p > 25'sd32767) begin
            return 16'sh7fff;
        end else if (p < -25'sd32768) begin
            return 16'sh8000;
        end else begin
            return p[15:0];
        end
    endfunction

endpackage

// File: rtl/deq_step_rom.sv
// Combinational lookup of the dequantization step for a raster index.
module deq_step_rom
    import image_codec_pkg::*;
#(
    parameter int unsigned STEP_W = 8
) (
    input  logic [5:0]        idx,
    output logic [STEP_W-1:0] step
);

    assign step = STEP_W'(DEQ_STEP[idx]);

endmodule

// File: rtl/dequantization.sv
// Streaming dequantizer: coefficient * step, saturated to 16 bits, through a
// two-stage pipeline that stalls as a whole on output backpressure.
module dequantization
    import image_codec_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [5:0]        out_pos,
    output logic              out_last,
    output logic              len_err
);

    localparam int unsigned MUL_W = DATA_W + STEP_W + 1;

    logic [5:0]              pos_q;
    logic [STEP_W-1:0]       step;
    logic                    advance;
    logic                    in_xfer;
    logic                    at_end;
    logic signed [MUL_W-1:0] prod;

    logic                    s1_valid_q;
    logic signed [MUL_W-1:0] s1_prod_q;
    logic [5:0]              s1_pos_q;
    logic                    s2_valid_q;
    logic [DATA_W-1:0]       s2_data_q;
    logic [5:0]              s2_pos_q;
    logic                    len_err_q;

    deq_step_rom #(
        .STEP_W (STEP_W)
    ) u_rom (
        .idx  (pos_q),
        .step (step)
    );

    always_comb begin
        advance = !s2_valid_q || out_ready;
        in_xfer = in_valid && advance;
        at_end  = (pos_q == 6'd63);
        // Step is unsigned; zero-extend before the signed multiply.
        prod    = MUL_W'($signed(in_data)) * MUL_W'($signed({1'b0, step}));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q      <= '0;
            len_err_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_pos_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_pos_q   <= '0;
        end else begin
            if (in_xfer) begin
                // An early in_last restarts the block; a missing one just wraps.
                pos_q <= (in_last && !at_end) ? 6'd0 : pos_q + 6'd1;
            end
            len_err_q <= in_xfer && (in_last != at_end);
            if (advance) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_prod_q <= prod;
                    s1_pos_q  <= pos_q;
                end
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= DATA_W'(sat16(s1_prod_q));
                    s2_pos_q  <= s1_pos_q;
                end
            end
        end
    end

    always_comb begin
        in_ready  = advance;
        out_valid = s2_valid_q;
        out_data  = s2_data_q;
        out_pos   = s2_pos_q;
        out_last  = s2_valid_q && (s2_pos_q == 6'd63);
        len_err   = len_err_q;
    end

endmodule

// File: tb/tb_dequantization.sv
// Self-checking bench for dequantization: scoreboard of expected outputs,
// table-driven directed block and hand-written length/reset sequences.
module tb_dequantization;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [5:0]  out_pos;
    logic        out_last;
    logic        len_err;

    dequantization dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pos   (out_pos),
        .out_last  (out_last),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int TB_STEP [64] = '{
        16, 12, 14, 21, 32, 51, 64, 85,
        13, 13, 18, 28, 43, 64, 85, 85,
        18, 21, 32, 43, 64, 85, 85, 85,
        26, 32, 43, 64, 85, 85, 85, 128,
        37, 51, 64, 85, 85, 85, 128, 128,
        51, 64, 85, 85, 85, 128, 128, 128,
        64, 85, 85, 85, 128, 128, 128, 128,
        85, 85, 85, 128, 128, 128, 128, 128
    };

    typedef struct {
        logic signed [15:0] d;
        logic [5:0]         pos;
        logic               last;
    } exp_t;

    typedef struct {
        int                 idx;
        logic signed [15:0] d;
        logic signed [15:0] e;
    } vec_t;

    exp_t        sb[$];
    bit          err_at[int];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [5:0]  mpos;
    int          rdy_mode;
    bit          lat_pending, lat_armed;
    int          lat_cyc;
    bit          prev_stall = 0;
    logic [15:0] prev_data;
    logic [5:0]  prev_pos;
    logic        prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic signed [15:0] model(input logic signed [15:0] d,
                                                 input logic [5:0] p);
        int v;
        v = int'(d) * TB_STEP[p];
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    // Drive one coefficient and wait for its transfer; queue what must come out.
    task automatic send(input logic signed [15:0] d, input logic last,
                        input bit use_exp, input logic signed [15:0] e);
        int   guard = 0;
        exp_t x;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && guard < 1000) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
        end else begin
            x.d    = use_exp ? e : model(d, mpos);
            x.pos  = mpos;
            x.last = (mpos == 6'd63);
            sb.push_back(x);
            if (last != (mpos == 6'd63)) err_at[cyc + 1] = 1'b1;
            if (lat_pending) begin
                lat_cyc     = cyc;
                lat_pending = 1'b0;
                lat_armed   = 1'b1;
            end
            mpos = (last && mpos != 6'd63) ? 6'd0 : mpos + 6'd1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic stream(input int n, input int mode);
        logic signed [15:0] d;
        for (int i = 0; i < n; i++) begin
            if (mode == 0) d = 16'sd1;
            else if ($urandom_range(0, 7) == 0) d = 16'($urandom);
            else d = 16'($urandom_range(0, 2000)) - 16'sd1000;
            send(d, mpos == 6'd63, 1'b0, '0);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d outputs still pending, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        err_at.delete();
        mpos        = '0;
        lat_pending = 1'b1;
        lat_armed   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("len_err", int'(len_err), int'(err_at.exists(cyc)));
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), int'(prev_data));
                chk("hold_pos", int'(out_pos), int'(prev_pos));
                chk("hold_last", int'(out_last), int'(prev_last));
            end
            if (lat_armed && out_valid) begin
                chk("latency", cyc - lat_cyc, 2);
                lat_armed = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    x = sb.pop_front();
                    chk("out_data", int'($signed(out_data)), int'(x.d));
                    chk("out_pos", int'(out_pos), int'(x.pos));
                    chk("out_last", int'(out_last), int'(x.last));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_pos   = out_pos;
            prev_last  = out_last;
        end
    end

    vec_t               vecs [7];
    logic signed [15:0] blk_d [64];
    logic signed [15:0] blk_e [64];
    bit                 blk_use [64];

    initial begin
        vecs[0] = '{0,  16'sd3,     16'sd48};
        vecs[1] = '{1,  -16'sd5,    -16'sd60};
        vecs[2] = '{7,  16'sd400,   16'sd32767};
        vecs[3] = '{63, -16'sd300,  -16'sd32768};
        vecs[4] = '{36, 16'sd2,     16'sd170};
        vecs[5] = '{12, -16'sd1000, -16'sd32768};
        vecs[6] = '{20, 16'sd100,   16'sd6400};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        rdy_mode = 0; out_ready = 1'b1;
        mpos = '0; lat_pending = 1'b1; lat_armed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_pos", int'(out_pos), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_len_err", int'(len_err), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Unit input exposes the step table in order.
        stream(64, 0);
        drain();

        // Directed values, including both saturation limits.
        for (int i = 0; i < 64; i++) begin
            blk_d[i] = '0; blk_e[i] = '0; blk_use[i] = 1'b0;
        end
        foreach (vecs[k]) begin
            blk_d[vecs[k].idx]   = vecs[k].d;
            blk_e[vecs[k].idx]   = vecs[k].e;
            blk_use[vecs[k].idx] = 1'b1;
        end
        for (int i = 0; i < 64; i++) send(blk_d[i], i == 63, blk_use[i], blk_e[i]);
        drain();

        // Three blocks with random backpressure.
        rdy_mode = 1;
        stream(192, 1);
        drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Early in_last at index 10; next coefficient restarts at index 0.
        stream(10, 1);
        send(-16'sd77, 1'b1, 1'b0, '0);
        send(16'sd7, 1'b0, 1'b1, 16'sd112);
        stream(63, 1);
        drain();

        // Index 63 without in_last; position wraps.
        stream(63, 1);
        send(16'sd55, 1'b0, 1'b0, '0);
        send(-16'sd2, 1'b0, 1'b1, -16'sd32);
        stream(63, 1);
        drain();

        // Reset with two coefficients in flight at index 20.
        stream(20, 1);
        drain();
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send(16'sd9, 1'b0, 1'b0, '0);
        send(16'sd11, 1'b0, 1'b0, '0);
        @(negedge clk);
        chk("stalled_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        do_reset();
        rdy_mode = 0;
        @(negedge clk);
        chk("midreset_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        send(16'sd2, 1'b0, 1'b1, 16'sd32);
        stream(63, 1);
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
        $finish;
    end

endmodule
